// File: rtl/divisor_frc_prog_if.sv
// Control and status bundle for the programmable clock divider.
// Master drives enable/restart/load; slave returns waveform and handshake.
interface divisor_frc_prog_if #(
    parameter int WIDTH = 26
);
    logic             en;
    logic             restart;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clk2;
    logic             tick;
    logic             div_pend;
    logic             div_ack;
    logic             div_err;

    modport master (
        output en, restart, div_in, div_load,
        input  clk2, tick, div_pend, div_ack, div_err
    );

    modport slave (
        input  en, restart, div_in, div_load,
        output clk2, tick, div_pend, div_ack, div_err
    );
endinterface

// File: rtl/divisor_frc_prog.sv
// Runtime-programmable divider: square wave plus per-period tick.
// New ratios are staged and swapped in only at period boundaries.
module divisor_frc_prog #(
    parameter int WIDTH       = 26,
    parameter int DIV_DEFAULT = 50_000_000
) (
    input logic               clk,
    input logic               rst,
    divisor_frc_prog_if.slave bus
);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk2_q, clk2_d;
    logic             tick_q, tick_d;
    logic             pflag_q, pflag_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wrap;

    assign wrap = (cnt_q == div_q - WIDTH'(1));

    always_comb begin
        div_d   = div_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        pflag_d = pflag_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        if (bus.restart) begin
            cnt_d = '0;
        end else if (bus.en) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pflag_q) begin
                    div_d   = pend_q;
                    pflag_d = 1'b0;
                    ack_d   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (pflag_q) begin
            // Frozen counter: apply immediately from a clean phase.
            div_d   = pend_q;
            cnt_d   = '0;
            pflag_d = 1'b0;
            ack_d   = 1'b1;
        end

        // Capture after application so a same-edge load stays pending.
        if (bus.div_load) begin
            if (bus.div_in < WIDTH'(2)) begin
                err_d = 1'b1;
            end else begin
                pend_d  = bus.div_in;
                pflag_d = 1'b1;
            end
        end

        clk2_d = (cnt_d >= (div_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= DIV_RST;
            pend_q  <= '0;
            cnt_q   <= '0;
            clk2_q  <= 1'b0;
            tick_q  <= 1'b0;
            pflag_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            clk2_q  <= clk2_d;
            tick_q  <= tick_d;
            pflag_q <= pflag_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.clk2     = clk2_q;
    assign bus.tick     = tick_q;
    assign bus.div_pend = pflag_q;
    assign bus.div_ack  = ack_q;
    assign bus.div_err  = err_q;
endmodule

// File: tb/tb_divisor_frc_prog.sv
// Directed bench for divisor_frc_prog: vector table plus corner sequences.
// Outputs compared as {clk2, tick, div_pend, div_ack, div_err}.
module tb_divisor_frc_prog;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    divisor_frc_prog_if #(.WIDTH(W)) ifa ();
    divisor_frc_prog_if #(.WIDTH(W)) ifb ();

    divisor_frc_prog #(.WIDTH(W), .DIV_DEFAULT(6)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    divisor_frc_prog #(.WIDTH(W), .DIV_DEFAULT(5)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // ctl = {rst, en, restart, div_load}
    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] din;
        logic [4:0]   exp;
    } vec_t;

    vec_t tbl [32];

    function automatic logic [4:0] outs_a();
        return {ifa.clk2, ifa.tick, ifa.div_pend, ifa.div_ack, ifa.div_err};
    endfunction

    function automatic logic [4:0] outs_b();
        return {ifb.clk2, ifb.tick, ifb.div_pend, ifb.div_ack, ifb.div_err};
    endfunction

    task automatic chk(input string nm, input logic [4:0] got,
                       input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] ctl, input logic [W-1:0] din,
                        input logic [4:0] exp, input string nm);
        rst_a        = ctl[3];
        ifa.en       = ctl[2];
        ifa.restart  = ctl[1];
        ifa.div_load = ctl[0];
        ifa.div_in   = din;
        @(posedge clk);
        #1;
        chk(nm, outs_a(), exp);
    endtask

    // Free-running stretch with a known divisor from a known count.
    task automatic run(input int div, input int c0, input int n,
                       input logic p, input string nm);
        for (int i = 1; i <= n; i++) begin
            int c;
            c = (c0 + i) % div;
            step(4'b0100, '0,
                 {(c >= div / 2), (c == 0), p, 1'b0, 1'b0},
                 $sformatf("%s_%0d", nm, i));
        end
    endtask

    initial begin
        tbl = '{
            '{4'b1100, 8'd0, 5'b00000},
            '{4'b1100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b01000},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b01000},
            '{4'b0101, 8'd1, 5'b00001},
            '{4'b0101, 8'd0, 5'b00001},
            '{4'b0101, 8'd4, 5'b10100},
            '{4'b0100, 8'd0, 5'b10100},
            '{4'b0100, 8'd0, 5'b10100},
            '{4'b0100, 8'd0, 5'b01010},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b01000},
            '{4'b0100, 8'd0, 5'b00000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0100, 8'd0, 5'b10000},
            '{4'b0000, 8'd0, 5'b10000},
            '{4'b0000, 8'd0, 5'b10000},
            '{4'b0001, 8'd8, 5'b10100},
            '{4'b0000, 8'd0, 5'b00010},
            '{4'b0000, 8'd0, 5'b00000}
        };

        rst_a        = 1'b1;
        rst_b        = 1'b1;
        ifa.en       = 1'b0;
        ifa.restart  = 1'b0;
        ifa.div_load = 1'b0;
        ifa.div_in   = '0;
        ifb.en       = 1'b1;
        ifb.restart  = 1'b0;
        ifb.div_load = 1'b0;
        ifb.div_in   = '0;

        // Reset, div 6 waveform, rejected loads, 6->4 swap, hold and load 8.
        for (int i = 0; i < 32; i++)
            step(tbl[i].ctl, tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));

        run(8, 0, 8, 1'b0, "div8");

        // Last of two loads wins; a load on the wrap edge stays pending.
        step(4'b0101, 8'd10, 5'b00100, "ld10");
        step(4'b0101, 8'd12, 5'b00100, "ld12");
        run(8, 2, 5, 1'b1, "pend12");
        step(4'b0101, 8'd9, 5'b01110, "wrap_ld9");
        run(12, 0, 11, 1'b1, "div12");
        step(4'b0100, 8'd0, 5'b01010, "ack9");
        run(9, 0, 8, 1'b0, "div9");

        // Load on a wrap with nothing pending waits a full period.
        step(4'b0101, 8'd3, 5'b01100, "wrap_ld3");
        run(9, 0, 8, 1'b1, "div9b");
        step(4'b0100, 8'd0, 5'b01010, "ack3");
        run(3, 0, 2, 1'b0, "div3");

        // Restart on the wrap cycle suppresses tick and keeps pending.
        step(4'b0110, 8'd0, 5'b00000, "rs_wrap");
        step(4'b0101, 8'd4, 5'b10100, "ld4");
        step(4'b0110, 8'd0, 5'b00100, "rs_pend");
        run(3, 0, 2, 1'b1, "div3b");
        step(4'b0100, 8'd0, 5'b01010, "ack4");

        // Mid-period reset at cnt 4 with a divisor pending.
        step(4'b0101, 8'd8, 5'b00100, "ld8b");
        run(4, 1, 2, 1'b1, "div4");
        step(4'b0100, 8'd0, 5'b01010, "ack8");
        run(8, 0, 3, 1'b0, "div8b");
        step(4'b0101, 8'd5, 5'b10100, "ld5");
        step(4'b1101, 8'd7, 5'b00000, "rst_mid");
        run(6, 0, 6, 1'b0, "post_rst");

        // Odd default divisor on the second instance.
        @(posedge clk);
        #1;
        chk("b_rst", outs_b(), 5'b00000);
        rst_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            int c;
            @(posedge clk);
            #1;
            c = k % 5;
            chk($sformatf("b_div5_%0d", k), outs_b(),
                {(c >= 2), (c == 0), 3'b000});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
